bmp180_button_ctrl: RTL and testbench
=====================================

Name: bmp180_button_ctrl

Overview:
- Front-end for the BMP180 controller. Takes the 7 raw board push-buttons and produces the clean single-cycle mode strobes the controller consumes: swId, swSettings, swTemp, swGTemp, swPress, swGPress, swShow.
- Per-button path: 2-flop synchroniser, debounce counter, press-edge detector, pending latch.
- A small FSM issues one strobe at a time. It issues only when the I2C master reports ready, and it waits out each transaction before issuing the next.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples needed to accept a new button level (10 ms at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 means a raw button reads 0 when pressed; 0 means it reads 1 when pressed.
- BUSY_TIMEOUT, 16, cycles to wait for ready to drop after a strobe before the request is treated as local-only (for example swShow).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; one clock domain (clk).
- btn  in  7  raw buttons; bit order [0]=Id, [1]=Settings, [2]=Temp, [3]=GTemp, [4]=Press, [5]=GPress, [6]=Show.
- ready  in  1  ready output of the I2C master.
- swId, swSettings, swTemp, swGTemp, swPress, swGPress, swShow  out  1 each  one-cycle mode strobes to the BMP180 controller.
- pending  out  7  latched, not-yet-issued requests (same bit order as btn).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All strobes, pending and busy are 0; FSM is in IDLE.
  - Synchroniser flops and debounced levels are set to the "released" value, so a button held through reset does not generate a press.
  - Debounce counters are 0.
- Polarity: the synchronised level is normalised so that 1 means pressed.
- Debounce (per bit):
  - While the synchronised level equals the debounced level, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - Any glitch back to the old level before that point clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1; it saturates and never wraps.
- Press detection: a rising edge of the debounced level sets pending[i] on the next cycle. Releases are ignored.
  - A second press of a button that is already pending is absorbed; there is no queue depth beyond 1 per button.
- FSM states:
  - IDLE: if pending is non-zero and ready=1, select the lowest-index set bit (fixed priority Id > Settings > … > Show) and go to ISSUE.
  - ISSUE: assert exactly that one strobe for exactly one cycle, clear its pending bit in the same cycle, load the timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: if ready=0, go to WAIT_DONE. Otherwise decrement the timer; at 0, go to IDLE.
  - WAIT_DONE: when ready=1, go to IDLE.
- Latency: from the debounced edge to the strobe, a minimum of 2 cycles (pending set, then ISSUE) when idle and ready=1.
- Simultaneous events:
  - Several buttons becoming pending in one cycle are issued in priority order, one per transaction.
  - A press of the button currently being issued, arriving in the ISSUE cycle, re-sets its pending bit (set wins over clear).
- Strobes are mutually exclusive and never asserted outside ISSUE.
- Reset mid-transaction aborts immediately; all pending requests are lost.

Test Plan:
- DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1: hold btn[2]=0 for 10 cycles with ready=1 → swTemp high for exactly 1 cycle, 2 cycles after debounce completes; no other strobe; pending returns to 0.
- Bounce btn[0] 0/1/0 with 2-cycle pulses, then release → no swId, pending stays 0. Then a clean 6-cycle press → one swId.
- Press btn[4] and btn[1] in the same cycle, ready=1, model the master dropping ready for 5 cycles after each strobe → swSettings first, swPress only after ready returns high; busy is high throughout both transactions.
- Press btn[6] while ready stays 1 permanently → swShow pulse, FSM returns to IDLE after BUSY_TIMEOUT=16 cycles; a second btn[6] press in that window is issued afterwards.
- Hold ready=0, press btn[3] → pending=7'b0001000 and no strobe; raise ready → swGTemp one cycle later.
- Assert reset=0 asynchronously in WAIT_DONE with pending=7'b0100000 → busy, pending and all strobes are 0 immediately; no strobe after release while the buttons are held.

Source files
------------

// File: rtl/bmp180_button_ctrl_if.sv
// bmp180_button_ctrl_if: board buttons and I2C-master ready in, single-cycle
// mode strobes, pending requests and busy out.
interface bmp180_button_ctrl_if;
   logic [6:0] btn;
   logic       ready;
   logic       swId;
   logic       swSettings;
   logic       swTemp;
   logic       swGTemp;
   logic       swPress;
   logic       swGPress;
   logic       swShow;
   logic [6:0] pending;
   logic       busy;

   // Button front-end side: drives the mode strobes toward the controller.
   modport master (
      input  btn, ready,
      output swId, swSettings, swTemp, swGTemp, swPress, swGPress, swShow,
      output pending, busy
   );

   // Board / controller side.
   modport slave (
      output btn, ready,
      input  swId, swSettings, swTemp, swGTemp, swPress, swGPress, swShow,
      input  pending, busy
   );
endinterface

// File: rtl/bmp180_button_ctrl.sv
// bmp180_button_ctrl: turns seven raw push-buttons into one-at-a-time mode
// strobes for the BMP180 controller. Each button is synchronised, debounced,
// edge-detected and latched as a pending request; a small FSM issues the
// lowest-index pending request whenever the I2C master is ready, then waits
// out the transaction it started.
module bmp180_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
   parameter int unsigned BUSY_TIMEOUT    = 16
) (
   input logic                  clk,
   input logic                  reset,
   bmp180_button_ctrl_if.master bus
);

   localparam int NB    = 7;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 2);

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB-1:0]    RAW_RELEASED = {NB{BTN_ACTIVE_LOW}};

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   // Button path
   logic [NB-1:0]    sync1_q, sync2_q;
   logic [NB-1:0]    lvl;
   logic [CNT_W-1:0] cnt_q [NB];
   logic [CNT_W-1:0] cnt_d [NB];
   logic [NB-1:0]    deb_q, deb_d;
   logic [NB-1:0]    deb_dly_q;
   logic [NB-1:0]    armed_q;
   logic [1:0]       prime_q;
   logic [NB-1:0]    press;

   // Issue FSM
   logic [1:0]       state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       low_idx;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [NB-1:0]    pend_q, pend_d;
   logic [NB-1:0]    strobe;

   // Two-flop synchroniser; both stages park at the released level in reset.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: clocked blocks use non-blocking assignments so every flop
      // samples the values from before the edge, whatever the statement order.
      if (!reset) begin
         sync1_q <= RAW_RELEASED;
         sync2_q <= RAW_RELEASED;
      end else begin
         sync1_q <= bus.btn;
         sync2_q <= sync1_q;
      end
   end

   // Normalise polarity so that 1 always means pressed.
   assign lvl = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

   // Per-bit debounce: a new level is accepted after DEBOUNCE_CYCLES
   // consecutive differing samples; any agreeing sample restarts the count.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise an unassigned path would infer a latch.
      deb_d = deb_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (lvl[i] != deb_q[i]) begin
            if (cnt_q[i] >= CNT_LAST) begin
               deb_d[i] = lvl[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state, press-edge history, and arming. A button only arms once
   // it has been seen released through a refilled synchroniser, so a button
   // held through reset never produces a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the counters are a small flop array, not a RAM, so they are
         // cleared in reset like any other state.
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         armed_q   <= '0;
         prime_q   <= '0;
      end else begin
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         prime_q   <= {prime_q[0], 1'b1};
         if (prime_q[1]) armed_q <= armed_q | ~lvl;
      end
   end

   // Rising edge of the debounced level; releases are ignored.
   assign press = deb_q & ~deb_dly_q & armed_q;

   // Fixed priority: the lowest-index pending request wins.
   always_comb begin
      low_idx = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (pend_q[i]) low_idx = 3'(i);
      end
   end

   // Exactly one strobe, only while in ISSUE.
   assign strobe = (state_q == S_ISSUE) ? (NB'(1) << sel_q) : '0;

   // Next state for the issue FSM and the pending latch. A press landing in
   // the ISSUE cycle of the same button re-arms its request (set beats clear).
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            if ((|pend_q) && bus.ready) begin
               sel_d   = low_idx;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmr_d   = TMR_W'(BUSY_TIMEOUT);
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // A master that never drops ready (local-only request) is
            // released after BUSY_TIMEOUT cycles.
            if (!bus.ready) begin
               state_d = S_WAIT_DONE;
            end else if (tmr_q <= TMR_W'(1)) begin
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (bus.ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      pend_d = (pend_q & ~strobe) | press;
   end

   // FSM and pending registers; reset aborts any transaction and drops requests.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         tmr_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tmr_q   <= tmr_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.swId       = strobe[0];
   assign bus.swSettings = strobe[1];
   assign bus.swTemp     = strobe[2];
   assign bus.swGTemp    = strobe[3];
   assign bus.swPress    = strobe[4];
   assign bus.swGPress   = strobe[5];
   assign bus.swShow     = strobe[6];
   assign bus.pending    = pend_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bmp180_button_ctrl.sv
// tb_bmp180_button_ctrl: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model of the button front-end.
module tb_bmp180_button_ctrl;

   localparam int DC = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;

   initial forever #5 clk = ~clk;

   bmp180_button_ctrl_if bus();

   bmp180_button_ctrl #(
      .DEBOUNCE_CYCLES(DC),
      .BTN_ACTIVE_LOW (1'b1),
      .BUSY_TIMEOUT   (TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Stimulus
   logic [6:0] btn_raw;
   logic       ready_man;
   logic       resp_en;
   logic       resp_ready;
   logic       resp_rand;
   int         resp_len;
   int         resp_cnt;
   int         resp_tmp;

   assign bus.btn   = btn_raw;
   assign bus.ready = resp_en ? resp_ready : ready_man;

   logic [6:0] dut_strb;
   assign dut_strb = {bus.swShow, bus.swGPress, bus.swPress, bus.swGTemp,
                      bus.swTemp, bus.swSettings, bus.swId};

   // Bookkeeping
   int checks = 0;
   int errors = 0;
   int strb_cnt [7];
   int order_q [$];
   int when_q [$];
   int cyc = 0;
   bit t3_track = 1'b0;
   int busy_gap = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- behavioural model ----------------
   // Button side: a synchronised sample is the raw value two edges old; a
   // button's accepted level flips when the last DC samples all disagree with
   // it; a rise becomes a request one edge later if the button was ever seen
   // released since reset. Issue side: spec-level transaction phases.
   logic [6:0] m_pend, m_deb, m_armed, m_rose;
   int         m_phase;   // 0 idle, 1 issuing, 2 waiting for ready to drop, 3 waiting for ready to return
   int         m_sel;
   int         m_wait;
   logic [6:0] raw_hist [$];
   logic [6:0] win [$];

   task automatic model_clear();
      m_pend = '0; m_deb = '0; m_armed = '0; m_rose = '0;
      m_phase = 0; m_sel = 0; m_wait = 0;
      raw_hist.delete();
      win.delete();
   endtask

   task automatic model_edge();
      logic [6:0] lvl, pset, clr, flip;
      logic       rdy;
      bit         real_smp;
      bit         all_diff;
      int         low;
      rdy      = bus.ready;
      real_smp = (raw_hist.size() >= 2);
      lvl      = real_smp ? ~raw_hist[raw_hist.size() - 2] : 7'b0;
      raw_hist.push_back(btn_raw);
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());

      pset = m_rose & m_armed;
      if (real_smp) m_armed = m_armed | ~lvl;

      win.push_back(lvl);
      if (win.size() > DC) void'(win.pop_front());
      flip = '0;
      if (win.size() == DC) begin
         for (int i = 0; i < 7; i++) begin
            all_diff = 1'b1;
            foreach (win[j]) if (win[j][i] == m_deb[i]) all_diff = 1'b0;
            flip[i] = all_diff;
         end
      end
      m_rose = flip & ~m_deb;
      m_deb  = m_deb ^ flip;

      clr = '0;
      case (m_phase)
         0: if (m_pend != 0 && rdy) begin
               low = 0;
               while (low < 6 && !m_pend[low]) low++;
               m_sel   = low;
               m_phase = 1;
            end
         1: begin
               clr[m_sel] = 1'b1;
               m_wait  = 0;
               m_phase = 2;
            end
         2: if (!rdy) m_phase = 3;
            else begin
               m_wait++;
               if (m_wait == TO) m_phase = 0;
            end
         default: if (rdy) m_phase = 0;
      endcase
      m_pend = (m_pend & ~clr) | pset;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_clear();
         else        model_edge();
      end
   end

   // ---------------- compare process ----------------
   initial begin
      logic [6:0] exp_strb;
      forever begin
         @(negedge clk);
         cyc++;
         exp_strb = (reset && m_phase == 1) ? (7'd1 << m_sel) : 7'd0;
         if (!reset)
            check("model", {dut_strb, bus.pending, bus.busy}, 15'd0);
         else
            check("model", {dut_strb, bus.pending, bus.busy},
                  {exp_strb, m_pend, (m_phase != 0)});
         for (int i = 0; i < 7; i++) begin
            if (dut_strb[i] === 1'b1) begin
               strb_cnt[i]++;
               order_q.push_back(i);
               when_q.push_back(cyc);
            end
         end
         if (t3_track && bus.ready === 1'b0 && bus.busy !== 1'b1) busy_gap++;
      end
   end

   // ---------------- I2C master responder ----------------
   // After each strobe, drop ready for resp_len edges (random length when
   // resp_rand; zero means ready never drops, i.e. a local-only request).
   initial forever begin
      @(negedge clk);
      #1;
      if (!resp_en) begin
         resp_cnt   = 0;
         resp_ready = 1'b1;
      end else if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) resp_ready = 1'b1;
      end else if (dut_strb != 7'd0) begin
         resp_tmp = resp_rand ? int'($urandom_range(0, 6)) : resp_len;
         if (resp_tmp > 0) begin
            resp_cnt   = resp_tmp;
            resp_ready = 1'b0;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int base;
      btn_raw    = 7'h7f;
      ready_man  = 1'b1;
      resp_en    = 1'b0;
      resp_ready = 1'b1;
      resp_rand  = 1'b0;
      resp_len   = 5;
      resp_cnt   = 0;
      resp_tmp   = 0;
      for (int i = 0; i < 7; i++) strb_cnt[i] = 0;

      repeat (3) @(posedge clk);
      #2;
      check("reset_state", {dut_strb, bus.pending, bus.busy}, 15'd0);
      reset = 1'b1;
      step(6);

      // 1: clean 10-cycle press of Temp, ready high.
      btn_raw[2] = 1'b0;
      step(7);
      check("t1_pending", bus.pending, 7'b0000100);
      check("t1_no_early_strobe", dut_strb, 7'd0);
      step(1);
      check("t1_swTemp", dut_strb, 7'b0000100);
      step(1);
      check("t1_single_cycle", dut_strb, 7'd0);
      check("t1_pending_cleared", bus.pending, 7'd0);
      step(1);
      btn_raw[2] = 1'b1;
      step(30);

      // 2: bounce on Id, then a clean press.
      base = strb_cnt[0];
      btn_raw[0] = 1'b0; step(2);
      btn_raw[0] = 1'b1; step(2);
      btn_raw[0] = 1'b0; step(2);
      btn_raw[0] = 1'b1; step(12);
      check("t2_bounce_pending", bus.pending, 7'd0);
      check("t2_bounce_no_swId", strb_cnt[0] - base, 0);
      btn_raw[0] = 1'b0; step(6);
      btn_raw[0] = 1'b1; step(30);
      check("t2_clean_swId", strb_cnt[0] - base, 1);

      // 3: Press and Settings together; master drops ready for 5 cycles.
      resp_en  = 1'b1;
      resp_len = 5;
      order_q.delete();
      when_q.delete();
      busy_gap = 0;
      t3_track = 1'b1;
      btn_raw[4] = 1'b0; btn_raw[1] = 1'b0;
      step(8);
      btn_raw[4] = 1'b1; btn_raw[1] = 1'b1;
      step(60);
      t3_track = 1'b0;
      check("t3_strobe_count", order_q.size(), 2);
      check("t3_first_settings", (order_q.size() > 0) ? order_q[0] : -1, 1);
      check("t3_second_press", (order_q.size() > 1) ? order_q[1] : -1, 4);
      check("t3_gap", (when_q.size() > 1) ? when_q[1] - when_q[0] : -1, 7);
      check("t3_busy_held", busy_gap, 0);

      // 4: Show with ready stuck high; second press during the timeout window.
      resp_en = 1'b0;
      order_q.delete();
      when_q.delete();
      btn_raw[6] = 1'b0; step(6);
      btn_raw[6] = 1'b1; step(6);
      btn_raw[6] = 1'b0; step(6);
      btn_raw[6] = 1'b1; step(50);
      check("t4_two_swShow", order_q.size(), 2);
      check("t4_gap", (when_q.size() > 1) ? when_q[1] - when_q[0] : -1, TO + 2);

      // 5: ready low holds off GTemp until it rises.
      ready_man = 1'b0;
      base = strb_cnt[3];
      btn_raw[3] = 1'b0; step(6);
      btn_raw[3] = 1'b1; step(10);
      check("t5_pending", bus.pending, 7'b0001000);
      check("t5_no_strobe", strb_cnt[3] - base, 0);
      ready_man = 1'b1;
      step(1);
      check("t5_swGTemp", dut_strb, 7'b0001000);
      step(30);

      // 6: asynchronous reset in WAIT_DONE with GPress pending.
      resp_en  = 1'b1;
      resp_len = 40;
      btn_raw[2] = 1'b0; step(6);
      btn_raw[2] = 1'b1; step(6);
      btn_raw[5] = 1'b0; step(10);
      check("t6_pending_before", bus.pending, 7'b0100000);
      check("t6_busy_before", bus.busy, 1'b1);
      btn_raw[2] = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("t6_reset_immediate", {dut_strb, bus.pending, bus.busy}, 15'd0);
      resp_en   = 1'b0;
      ready_man = 1'b1;
      step(2);
      reset = 1'b1;
      base = 0;
      for (int i = 0; i < 7; i++) base += strb_cnt[i];
      step(40);
      for (int i = 0; i < 7; i++) base -= strb_cnt[i];
      check("t6_no_strobe_held", base, 0);
      check("t6_pending_after", bus.pending, 7'd0);
      btn_raw = 7'h7f;
      step(20);

      // 7: random button activity with a randomized master.
      resp_en   = 1'b1;
      resp_rand = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 7; i++) begin
            if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
         end
         step(1);
      end
      btn_raw = 7'h7f;
      step(120);
      check("final_idle", {bus.pending, bus.busy}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
